// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a power-of-two byte FIFO and an eight-entry baud-rate table.
// The baud select is latched at every frame start; tx_done_o marks the last clock of each stop bit.
module uart_tx #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] buad_set_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       uart_txd_o,
   output logic       tx_busy_o,
   output logic       tx_done_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          fifo_full, fifo_empty, push, pop;

   state_e        state_q, state_d;
   logic [13:0]   div_q, div_d, cnt_q, cnt_d, sel_div;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          txd_q, txd_d;
   logic          bit_end, start_frame;

   always_comb begin
      sel_div = 14'd109;
      case (buad_set_i)
         3'd0:    sel_div = 14'd10417;
         3'd1:    sel_div = 14'd5208;
         3'd2:    sel_div = 14'd2604;
         3'd3:    sel_div = 14'd1736;
         3'd4:    sel_div = 14'd868;
         3'd5:    sel_div = 14'd434;
         3'd6:    sel_div = 14'd217;
         default: sel_div = 14'd109;
      endcase
   end

   // Full is judged on the registered count, so a pop in the same cycle never frees a slot early.
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = tx_valid_i && !fifo_full;
   assign tx_ready_o = !fifo_full;

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= tx_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (!push && pop) count_q <= count_q - CW'(1);
      end
   end

   assign bit_end = (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      txd_d       = txd_q;
      pop         = 1'b0;
      start_frame = 1'b0;
      tx_done_o   = 1'b0;

      if (state_q != StIdle) cnt_d = bit_end ? div_q - 14'd1 : cnt_q - 14'd1;

      unique case (state_q)
         StIdle: start_frame = !fifo_empty;
         StStart: begin
            if (bit_end) begin
               state_d   = StData;
               txd_d     = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = '0;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
                  txd_d   = 1'b1;
               end else begin
                  txd_d     = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               tx_done_o = 1'b1;
               if (!fifo_empty) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Back-to-back frames reuse this path so the next start bit follows the stop bit directly.
      if (start_frame) begin
         pop     = 1'b1;
         state_d = StStart;
         txd_d   = 1'b0;
         div_d   = sel_div;
         cnt_d   = sel_div - 14'd1;
         shift_d = fifo_mem[rd_ptr_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         div_q     <= '0;
         cnt_q     <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
      end
   end

   assign uart_txd_o = txd_q;
   assign tx_busy_o  = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: accepted bytes go into a queue; a line monitor rebuilds each
// frame from the 8N1 rules and the baud table, and checks waveform, done pulse and byte order.
module tb_uart_tx;
   localparam int unsigned DEPTH = 4;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [2:0] buad_set_i = 3'd0;
   logic [7:0] tx_data_i = 8'd0;
   logic       tx_valid_i = 1'b0;
   logic       tx_ready_o, uart_txd_o, tx_busy_o, tx_done_o;

   uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .buad_set_i (buad_set_i),
      .tx_data_i  (tx_data_i),
      .tx_valid_i (tx_valid_i),
      .tx_ready_o (tx_ready_o),
      .uart_txd_o (uart_txd_o),
      .tx_busy_o  (tx_busy_o),
      .tx_done_o  (tx_done_o)
   );

   always #5 clk_i = ~clk_i;

   int         tests = 0, fails = 0;
   int         div_tab [8] = '{10417, 5208, 2604, 1736, 868, 434, 217, 109};
   logic [7:0] exp_q [$];
   int         start_log [$];
   int         cyc = 0, last_done_cyc = 0;
   int         n_started = 0, n_done = 0, n_abort = 0;
   int         busy_err = 0, idle_err = 0, spur_done = 0;
   bit         in_frame = 1'b0, frame_now;
   int         k, fdiv, bn, wave_err, done_err;
   logic       eb;
   logic [7:0] exp_byte, dec;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         cyc++;
         if (rst_i) begin
            if (in_frame) begin
               check("aborted_wave", wave_err, 0);
               n_abort++;
            end
            in_frame = 1'b0;
            exp_q.delete();
            check("rst_txd", uart_txd_o, 1);
            check("rst_busy", tx_busy_o, 0);
            check("rst_ready", tx_ready_o, 1);
            check("rst_done", tx_done_o, 0);
         end else begin
            if (!in_frame && uart_txd_o == 1'b0 && exp_q.size() > 0) begin
               exp_byte = exp_q.pop_front();
               fdiv     = div_tab[buad_set_i];
               k        = 0;
               wave_err = 0;
               done_err = 0;
               dec      = 8'd0;
               in_frame = 1'b1;
               n_started++;
               start_log.push_back(cyc);
            end
            frame_now = in_frame;
            if (in_frame) begin
               bn = k / fdiv;
               eb = (bn == 0) ? 1'b0 : (bn == 9) ? 1'b1 : exp_byte[bn-1];
               if (uart_txd_o !== eb) wave_err++;
               if (tx_done_o !== (k == 10 * fdiv - 1)) done_err++;
               if (bn >= 1 && bn <= 8 && (k % fdiv) == fdiv / 2) dec[bn-1] = uart_txd_o;
               if (k == 10 * fdiv - 1) begin
                  check("frame_wave", wave_err, 0);
                  check("frame_done", done_err, 0);
                  check("frame_byte", dec, exp_byte);
                  n_done++;
                  last_done_cyc = cyc;
                  in_frame = 1'b0;
               end
               k++;
            end else begin
               if (uart_txd_o !== 1'b1) idle_err++;
               if (tx_done_o !== 1'b0) spur_done++;
            end
            if (tx_busy_o !== (frame_now || exp_q.size() > 0)) busy_err++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic push_now(input logic [7:0] b, output bit rdy);
      tx_data_i  = b;
      tx_valid_i = 1'b1;
      check("tx_ready", tx_ready_o, (exp_q.size() < DEPTH));
      rdy = tx_ready_o;
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
   endtask

   task automatic push(input logic [7:0] b, output bit rdy);
      @(negedge clk_i);
      push_now(b, rdy);
   endtask

   task automatic release_valid();
      @(negedge clk_i);
      tx_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (n_done < target && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      check("done_count", n_done, target);
   endtask

   task automatic wait_start(input int target, input int budget);
      int n = 0;
      while (n_started < target && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      check("start_count", n_started, target);
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      bit rdy;
      int t0, nacc, ns, nd, npush, n;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);

      // Single 0x55 frame at 434 clocks per bit, plus start latency.
      buad_set_i = 3'd5;
      push(8'h55, rdy);
      t0 = cyc;
      release_valid();
      wait_done(1, 5000);
      check("start_latency", start_log[0], t0 + 2);
      check("frame_len_b5", last_done_cyc - start_log[0] + 1, 4340);

      // Four back-to-back frames at 868 clocks per bit.
      buad_set_i = 3'd4;
      ns = n_started;
      nd = n_done;
      push(8'h00, rdy);
      push(8'hFF, rdy);
      push(8'hA5, rdy);
      push(8'h3C, rdy);
      release_valid();
      wait_done(nd + 4, 36000);
      check("b2b_span", last_done_cyc - start_log[ns] + 1, 4 * 8680);
      check("busy_at_last_done", tx_busy_o, 1);
      @(negedge clk_i);
      check("busy_after_last", tx_busy_o, 0);

      // FIFO fills while a frame is in flight; two extra bytes are refused.
      buad_set_i = 3'd7;
      ns = n_started;
      nd = n_done;
      push(8'h11, rdy);
      release_valid();
      wait_start(ns + 1, 100);
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         push(8'h20 + 8'(i), rdy);
         nacc += int'(rdy);
      end
      release_valid();
      check("full_accepted", nacc, 4);
      wait_done(nd + 5, 7000);

      // Push on the same edge as a pop with three bytes queued.
      ns = n_started;
      nd = n_done;
      push(8'hC1, rdy);
      release_valid();
      wait_start(ns + 1, 100);
      push(8'hC2, rdy);
      push(8'hC3, rdy);
      push(8'hC4, rdy);
      release_valid();
      n = 0;
      while (!tx_done_o && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      check("done_seen", tx_done_o, 1);
      push_now(8'hC5, rdy);
      release_valid();
      check("ready_after_simul", tx_ready_o, 1);
      push(8'hC6, rdy);
      push(8'hC7, rdy);
      release_valid();
      wait_done(nd + 6, 8000);

      // Reset during data bit 3 aborts the frame and drops the queued byte.
      ns = n_started;
      push(8'hA5, rdy);
      push(8'h3C, rdy);
      release_valid();
      wait_start(ns + 1, 100);
      repeat (4 * 109 + 50) @(negedge clk_i);
      nd = n_done;
      pulse_reset();
      repeat (1500) @(negedge clk_i);
      check("no_frame_after_rst", n_started, ns + 1);
      check("no_done_after_rst", n_done, nd);
      check("abort_count", n_abort, 1);

      // Start-bit length at the slower rates, cut short by reset.
      for (int b = 2; b <= 3; b++) begin
         buad_set_i = 3'(b);
         ns = n_started;
         push(8'hFF, rdy);
         release_valid();
         wait_start(ns + 1, 50);
         repeat (div_tab[b] + 20) @(negedge clk_i);
         pulse_reset();
         repeat (10) @(negedge clk_i);
      end
      check("abort_count_slow", n_abort, 3);

      // Baud change mid-frame only affects the next frame.
      buad_set_i = 3'd5;
      ns = n_started;
      nd = n_done;
      push(8'h96, rdy);
      push(8'h69, rdy);
      release_valid();
      wait_start(ns + 1, 100);
      repeat (1000) @(negedge clk_i);
      buad_set_i = 3'd7;
      wait_done(nd + 2, 6000);
      check("old_baud_frame", start_log[ns + 1] - start_log[ns], 4340);
      check("new_baud_frame", last_done_cyc - start_log[ns + 1] + 1, 1090);

      // Random bytes, rates and gaps.
      nd = n_done;
      npush = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         buad_set_i = 3'(6 + $urandom_range(0, 1));
         if (exp_q.size() < DEPTH) npush++;
         push(8'($urandom), rdy);
         release_valid();
         repeat ($urandom_range(0, 400)) @(negedge clk_i);
      end
      wait_done(nd + npush, 16000);

      repeat (20) @(negedge clk_i);
      check("queue_drained", exp_q.size(), 0);
      check("busy_track", busy_err, 0);
      check("idle_line", idle_err, 0);
      check("spurious_done", spur_done, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
